rf_dump_reader: RTL and testbench
=================================

# rf_dump_reader

Sequential readback engine for the execution unit's register file: on command, it walks RF entries `0..iLastAddr`, reads the X, Y and Z banks of each entry, and streams the words out over a valid/ready interface. It is the read-side counterpart of the bench/host path that preloads memories. It sits beside `Unit_Execution` and gives the bench or host a result-dump path that does not depend on hierarchical peeks.

## Interface
- `DATA_WIDTH`, 32, width of one RF bank word
- `ADDR_WIDTH`, 5, RF address width (32 entries)
- `Clock` in 1: single clock, all logic rising-edge
- `Reset` in 1: synchronous, active-high
- `iStart` in 1: dump request, sampled only in IDLE
- `iLastAddr` in ADDR_WIDTH: final entry to dump, latched when iStart is accepted
- `oRfReadEnable` out 1: RF read strobe
- `oRfAddr` out ADDR_WIDTH: RF read address
- `iRfDataX`, `iRfDataY`, `iRfDataZ` in DATA_WIDTH each: bank read data, valid the cycle after `oRfReadEnable`
- `oData` out DATA_WIDTH: streamed word
- `oValid` out 1: `oData` valid
- `iReady` in 1: consumer accepts the beat when `oValid && iReady`
- `oLast` out 1: marks the final beat (Z of entry iLastAddr)
- `oBusy` out 1: high in every state except IDLE
- `oDone` out 1: one-cycle pulse after the final beat is accepted

## Operation
- States and transitions:
  - IDLE → ISSUE on iStart; address counter is set to 0 and iLastAddr is latched.
  - ISSUE: `oRfReadEnable=1`, `oRfAddr=addr`. Always → CAPTURE.
  - CAPTURE: latch iRfDataX/Y/Z into a 3-word buffer and set beat=0. Always → EMIT.
  - EMIT: `oValid=1`, `oData=buf[beat]`. Nothing changes while the beat is not accepted.
    - Beat 0/1 accepted → beat+1.
    - Beat 2 accepted, addr≠last → addr+1, go to ISSUE.
    - Beat 2 accepted, addr==last → DONE.
  - DONE: `oDone=1`. Always → IDLE.
- Beat order per entry: X, Y, Z. Entries are dumped in ascending address order.
- `oLast = (state==EMIT) && beat==2 && addr==lastLatched`.
- Address counter does not wrap; iLastAddr=2^ADDR_WIDTH−1 is legal and dumps all entries.
- iStart is ignored outside IDLE, including in DONE. iLastAddr changes after acceptance have no effect.
- RF data inputs are sampled only in CAPTURE.
- Once `oValid` is asserted, `oData`, `oValid` and `oLast` stay stable until the beat is accepted.

## Timing
- Reset values:
  - State IDLE.
  - `oRfReadEnable`, `oValid`, `oLast`, `oBusy`, `oDone` = 0.
  - `oRfAddr` = 0, `oData` = 0.
  - Buffer, beat and latched-last registers = 0.
- Reset asserted mid-dump: at the next edge the block is in IDLE with all outputs at reset values. The partial stream is abandoned. The next iStart restarts at address 0.
- Latency with iStart sampled at cycle T and iReady held high:
  - T+1 ISSUE (addr 0)
  - T+2 CAPTURE
  - T+3/T+4/T+5 beats X/Y/Z of entry 0
  - Entry k's X at T+3+5k, so each entry takes 5 cycles.
- Dump complete, last beat accepted at cycle L: `oDone` is high at L+1 and the block is in IDLE at L+2. An iStart sampled at L+2 is accepted.
- A stall on iReady delays all later beats cycle-for-cycle. There are no bubbles beyond the ISSUE/CAPTURE pair per entry.

## Structure
- Shared package `rf_dump_pkg` holds:
  - state enum: IDLE, ISSUE, CAPTURE, EMIT, DONE
  - beat constants: BEAT_X=0, BEAT_Y=1, BEAT_Z=2
  - 2-bit beat index typedef
- Single module, no sub-module. The 3-word buffer and beat mux stay inline. Expected size is roughly 150 RTL lines.
- The RF model in the bench provides the 1-cycle synchronous read behind `oRfReadEnable`.

## Test plan
- Entry `k` preloaded with X=0x1000+k, Y=0x2000+k, Z=0x3000+k; iLastAddr=3; iReady=1 → 12 beats: 0x1000, 0x2000, 0x3000, 0x1001, … 0x3003.
  - `oLast` only on 0x3003.
  - `oDone` high exactly 1 cycle after that beat.
  - First beat at T+3.
- Same preload; iLastAddr=0 → exactly 3 beats (0x1000, 0x2000, 0x3000). `oLast` on the third. `oRfAddr` never exceeds 0.
- iLastAddr=31; iReady toggled with a 1-on/2-off pattern → all 96 beats in order. `oData`/`oValid` held stable through every stall. No beat dropped or duplicated.
- iStart pulsed again during EMIT of entry 1 and during DONE → no restart; the stream is unchanged.
- Reset asserted for 1 cycle while beat Y of entry 2 is pending → next cycle all outputs are 0 and the block is in IDLE. A new iStart with iLastAddr=1 produces 6 beats starting at 0x1000.
- Full range iLastAddr=31, iReady=1 → `oRfAddr` goes 0..31 with no wrap. Final `oDone` at T+161. `oBusy` low from T+162.

Source files
------------

// File: rtl/rf_dump_pkg.sv
// Shared types for the register-file dump reader: FSM states and the
// X/Y/Z beat index used to walk the three bank words of each entry.
package rf_dump_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    EMIT    = 3'd3,
    DONE    = 3'd4
  } state_t;

  typedef logic [1:0] beat_t;

  localparam beat_t BEAT_X = 2'd0;
  localparam beat_t BEAT_Y = 2'd1;
  localparam beat_t BEAT_Z = 2'd2;

endpackage

// File: rtl/rf_dump_reader.sv
// Walks RF entries 0..iLastAddr, reads the X/Y/Z banks of each one and
// streams them out over valid/ready. All outputs come straight from flops.
module rf_dump_reader
  import rf_dump_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStart,
  input  logic [ADDR_WIDTH-1:0] iLastAddr,
  output logic                  oRfReadEnable,
  output logic [ADDR_WIDTH-1:0] oRfAddr,
  input  logic [DATA_WIDTH-1:0] iRfDataX,
  input  logic [DATA_WIDTH-1:0] iRfDataY,
  input  logic [DATA_WIDTH-1:0] iRfDataZ,
  output logic [DATA_WIDTH-1:0] oData,
  output logic                  oValid,
  input  logic                  iReady,
  output logic                  oLast,
  output logic                  oBusy,
  output logic                  oDone
);

  state_t                state_r, state_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_s;
  logic [ADDR_WIDTH-1:0] last_r, last_s;
  beat_t                 beat_r, beat_s;
  logic [DATA_WIDTH-1:0] buf_r [0:2];
  logic [DATA_WIDTH-1:0] buf_s [0:2];
  logic                  emit_s;

  function automatic logic [DATA_WIDTH-1:0] pick_beat(
    input logic [DATA_WIDTH-1:0] w0,
    input logic [DATA_WIDTH-1:0] w1,
    input logic [DATA_WIDTH-1:0] w2,
    input beat_t                 sel
  );
    case (sel)
      BEAT_X:  pick_beat = w0;
      BEAT_Y:  pick_beat = w1;
      BEAT_Z:  pick_beat = w2;
      default: pick_beat = {DATA_WIDTH{1'b0}};
    endcase
  endfunction

  // Next-state, address, beat and capture-buffer logic.
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    last_s  = last_r;
    beat_s  = beat_r;
    buf_s   = buf_r;
    case (state_r)
      IDLE: begin
        if (iStart) begin
          state_s = ISSUE;
          addr_s  = {ADDR_WIDTH{1'b0}};
          last_s  = iLastAddr;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: state_s = CAPTURE;
      CAPTURE: begin
        buf_s[0] = iRfDataX;
        buf_s[1] = iRfDataY;
        buf_s[2] = iRfDataZ;
        beat_s   = BEAT_X;
        state_s  = EMIT;
      end
      EMIT: begin
        if (!iReady) begin
          state_s = EMIT;
        end else if (beat_r != BEAT_Z) begin
          beat_s = beat_r + 2'd1;
        end else if (addr_r != last_r) begin
          addr_s  = addr_r + ADDR_WIDTH'(1);
          state_s = ISSUE;
        end else begin
          state_s = DONE;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  assign emit_s = (state_s == EMIT);

  // Core state registers and output flops, driven from next-state values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r       <= IDLE;
      addr_r        <= {ADDR_WIDTH{1'b0}};
      last_r        <= {ADDR_WIDTH{1'b0}};
      beat_r        <= BEAT_X;
      buf_r[0]      <= {DATA_WIDTH{1'b0}};
      buf_r[1]      <= {DATA_WIDTH{1'b0}};
      buf_r[2]      <= {DATA_WIDTH{1'b0}};
      oRfReadEnable <= 1'b0;
      oRfAddr       <= {ADDR_WIDTH{1'b0}};
      oData         <= {DATA_WIDTH{1'b0}};
      oValid        <= 1'b0;
      oLast         <= 1'b0;
      oBusy         <= 1'b0;
      oDone         <= 1'b0;
    end else begin
      state_r       <= state_s;
      addr_r        <= addr_s;
      last_r        <= last_s;
      beat_r        <= beat_s;
      buf_r         <= buf_s;
      oRfReadEnable <= (state_s == ISSUE);
      oRfAddr       <= addr_s;
      // Outside EMIT the data bus is parked at zero.
      oData         <= emit_s ? pick_beat(buf_s[0], buf_s[1], buf_s[2], beat_s)
                              : {DATA_WIDTH{1'b0}};
      oValid        <= emit_s;
      oLast         <= emit_s && (beat_s == BEAT_Z) && (addr_s == last_s);
      oBusy         <= (state_s != IDLE);
      oDone         <= (state_s == DONE);
    end
  end

endmodule

// File: tb/tb_rf_dump_reader.sv
// Randomized self-checking bench for rf_dump_reader: an RF model with
// 1-cycle read latency plus an expected-beat queue built from RF contents.
module tb_rf_dump_reader;

  logic        Clock;
  logic        Reset;
  logic        iStart;
  logic [4:0]  iLastAddr;
  logic        oRfReadEnable;
  logic [4:0]  oRfAddr;
  logic [31:0] iRfDataX, iRfDataY, iRfDataZ;
  logic [31:0] oData;
  logic        oValid;
  logic        iReady;
  logic        oLast;
  logic        oBusy;
  logic        oDone;

  logic [31:0] mem_x [32];
  logic [31:0] mem_y [32];
  logic [31:0] mem_z [32];

  int n_checks = 0;
  int n_fail   = 0;

  rf_dump_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iLastAddr(iLastAddr),
    .oRfReadEnable(oRfReadEnable), .oRfAddr(oRfAddr),
    .iRfDataX(iRfDataX), .iRfDataY(iRfDataY), .iRfDataZ(iRfDataZ),
    .oData(oData), .oValid(oValid), .iReady(iReady), .oLast(oLast),
    .oBusy(oBusy), .oDone(oDone)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // RF model: synchronous read, data valid the cycle after the strobe.
  always @(posedge Clock) begin
    if (oRfReadEnable) begin
      iRfDataX <= mem_x[oRfAddr];
      iRfDataY <= mem_y[oRfAddr];
      iRfDataZ <= mem_z[oRfAddr];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_rden"},  32'(oRfReadEnable), 32'd0);
    check_val({tag, "_addr"},  32'(oRfAddr),       32'd0);
    check_val({tag, "_data"},  oData,              32'd0);
    check_val({tag, "_valid"}, 32'(oValid),        32'd0);
    check_val({tag, "_last"},  32'(oLast),         32'd0);
    check_val({tag, "_busy"},  32'(oBusy),         32'd0);
    check_val({tag, "_done"},  32'(oDone),         32'd0);
  endtask

  task automatic preload_plan();
    for (int k = 0; k < 32; k++) begin
      mem_x[k] = 32'h1000 + 32'(k);
      mem_y[k] = 32'h2000 + 32'(k);
      mem_z[k] = 32'h3000 + 32'(k);
    end
  endtask

  task automatic preload_random();
    for (int k = 0; k < 32; k++) begin
      mem_x[k] = $urandom;
      mem_y[k] = $urandom;
      mem_z[k] = $urandom;
    end
  endtask

  // Called at #1 after a rising edge with the DUT idle. ready_mode:
  // 0 always ready, 1 one-on/two-off, 2 random. abort_at >= 0 resets the DUT
  // while beat number abort_at is pending.
  task automatic run_dump(input int last, input int ready_mode, input bit pulse_restart,
                          input int abort_at, input bit check_timing);
    logic [31:0] exp_q[$];
    logic [31:0] prev_data;
    logic        prev_last;
    bit          prev_stall = 1'b0;
    bit          finished   = 1'b0;
    bit          aborted    = 1'b0;
    int          cyc        = 1;
    int          issue_idx  = 0;
    int          last_acc   = -1;
    int          done_cyc   = -1;
    int          first_val  = -1;
    int          acc        = 0;
    prev_data = 32'd0;
    prev_last = 1'b0;
    for (int k = 0; k <= last; k++) begin
      exp_q.push_back(mem_x[k]);
      exp_q.push_back(mem_y[k]);
      exp_q.push_back(mem_z[k]);
    end
    iStart    = 1'b1;
    iLastAddr = 5'(last);
    @(posedge Clock); #1;
    iStart    = 1'b0;
    iLastAddr = 5'($urandom);
    while (!finished && cyc < 3000) begin
      check_val("busy", 32'(oBusy), 32'd1);
      if (oRfReadEnable) begin
        check_val("rf_addr", 32'(oRfAddr), 32'(issue_idx));
        issue_idx++;
      end
      if (prev_stall) begin
        check_val("stall_valid", 32'(oValid), 32'd1);
        check_val("stall_data",  oData,       prev_data);
        check_val("stall_last",  32'(oLast), 32'(prev_last));
      end
      check_val("done", 32'(oDone), 32'((last_acc >= 0) && (cyc == last_acc + 1)));
      iStart = 1'b0;
      if (oDone) begin
        finished = 1'b1;
        done_cyc = cyc;
        iReady   = 1'b0;
        if (pulse_restart) begin
          iStart    = 1'b1;
          iLastAddr = 5'($urandom);
        end
      end else begin
        case (ready_mode)
          0:       iReady = 1'b1;
          1:       iReady = ((cyc % 3) == 0);
          default: iReady = 1'($urandom_range(0, 1));
        endcase
        if (abort_at >= 0 && acc == abort_at && oValid) begin
          Reset    = 1'b1;
          iReady   = 1'b0;
          aborted  = 1'b1;
          finished = 1'b1;
        end else if (oValid) begin
          if (first_val < 0) first_val = cyc;
          if (pulse_restart && acc == 3) begin
            iStart    = 1'b1;
            iLastAddr = 5'd0;
          end
          if (iReady) begin
            if (exp_q.size() == 0) begin
              check_val("extra_beat", 32'd1, 32'd0);
            end else begin
              check_val("data", oData, exp_q[0]);
              check_val("last", 32'(oLast), 32'(exp_q.size() == 1));
              void'(exp_q.pop_front());
              acc++;
              if (exp_q.size() == 0) last_acc = cyc;
            end
            prev_stall = 1'b0;
          end else begin
            prev_stall = 1'b1;
            prev_data  = oData;
            prev_last  = oLast;
          end
        end else begin
          prev_stall = 1'b0;
        end
      end
      @(posedge Clock); #1;
      cyc++;
    end
    iStart = 1'b0;
    iReady = 1'b0;
    if (aborted) begin
      check_idle_outputs("after_reset");
      Reset = 1'b0;
    end else begin
      check_val("timeout", 32'(finished), 32'd1);
      check_val("beats_left", 32'(exp_q.size()), 32'd0);
      check_val("entries_issued", 32'(issue_idx), 32'(last + 1));
      if (check_timing) begin
        check_val("first_beat_cycle", 32'(first_val), 32'd3);
        check_val("done_cycle", 32'(done_cyc), 32'(5 * (last + 1) + 1));
      end
      check_val("idle_busy",  32'(oBusy),         32'd0);
      check_val("idle_rden",  32'(oRfReadEnable), 32'd0);
      check_val("idle_valid", 32'(oValid),        32'd0);
      check_val("idle_done",  32'(oDone),         32'd0);
    end
  endtask

  initial begin
    Reset     = 1'b1;
    iStart    = 1'b0;
    iReady    = 1'b0;
    iLastAddr = 5'd0;
    preload_plan();
    repeat (2) @(posedge Clock);
    #1;
    check_idle_outputs("reset");
    Reset = 1'b0;
    @(posedge Clock); #1;

    run_dump(3, 0, 1'b0, -1, 1'b1);
    run_dump(0, 0, 1'b0, -1, 1'b1);
    run_dump(31, 1, 1'b0, -1, 1'b0);
    run_dump(3, 0, 1'b1, -1, 1'b1);
    run_dump(5, 0, 1'b0, 7, 1'b0);
    run_dump(1, 0, 1'b0, -1, 1'b1);
    run_dump(31, 0, 1'b0, -1, 1'b1);

    preload_random();
    for (int r = 0; r < 6; r++) begin
      run_dump(int'($urandom_range(0, 31)), 2, 1'($urandom_range(0, 1)), -1, 1'b0);
      repeat (int'($urandom_range(0, 3))) begin
        @(posedge Clock); #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
